viterbi_frame_ctrl: RTL

VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

---
 rtl/viterbi_pkg.sv | 27 ++
 rtl/viterbi_err_lfsr.sv | 26 ++
 rtl/viterbi_frame_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi frame controller and its error-injection LFSR.
package viterbi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    TAIL  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } frame_state_t;

  localparam int          CNT_W     = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (register bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {m[1] & m[0], m[1] ^ m[0]};
  endfunction

endpackage

// File: rtl/viterbi_err_lfsr.sv
// 16-bit Fibonacci LFSR driving error injection; reloads the seed on reseed_i, steps on adv_i.
module viterbi_err_lfsr
  import viterbi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  input  logic        reseed_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (reseed_i) begin
      lfsr_reg <= LFSR_SEED;
    end else if (adv_i) begin
      lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end

  assign q_o = lfsr_reg;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for an encoder -> channel -> Viterbi decoder loop: DATA, zero TAIL, decoder DRAIN.
// Define VITERBI_ERR_INJECT_EN to build the LFSR-driven channel error mask and error counter.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int TAIL_LEN  = 2,
  parameter int DEC_LAT   = 64,
  parameter int ERR_N     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        data_i,
  output logic        enc_en_o,
  output logic        enc_d_o,
  output logic        dec_en_o,
  output logic [1:0]  err_mask_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] word_ct_o,
  output logic [15:0] err_ct_o
);

  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DEC_LAT - 1);

  if (FRAME_LEN < 1 || FRAME_LEN > 65535 || TAIL_LEN < 0 || TAIL_LEN > 15 ||
      DEC_LAT < 1 || DEC_LAT > 1023 || ERR_N < 1 || ERR_N > 8) begin : g_bad_params
    $error("viterbi_frame_ctrl: parameter out of range");
  end

  frame_state_t     state_reg, state_next;
  logic [CNT_W-1:0] phase_ct_reg, phase_ct_next;
  logic             dec_en_reg;
  logic [CNT_W-1:0] word_ct_reg;
  logic             start_ok;

  // phase_ct holds the number of cycles left in the current phase, minus one
  always_comb begin
    state_next    = state_reg;
    phase_ct_next = phase_ct_reg;
    start_ok      = 1'b0;
    enc_en_o      = 1'b0;
    enc_d_o       = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          start_ok      = 1'b1;
          state_next    = DATA;
          phase_ct_next = DATA_LAST;
        end
      end
      DATA: begin
        enc_en_o = 1'b1;
        enc_d_o  = data_i;
        if (phase_ct_reg == '0) begin
          if (TAIL_LEN == 0) begin
            state_next    = DRAIN;
            phase_ct_next = DRAIN_LAST;
          end else begin
            state_next    = TAIL;
            phase_ct_next = TAIL_LAST;
          end
        end else begin
          phase_ct_next = phase_ct_reg - 1'b1;
        end
      end
      TAIL: begin
        enc_en_o = 1'b1;
        if (phase_ct_reg == '0) begin
          state_next    = DRAIN;
          phase_ct_next = DRAIN_LAST;
        end else begin
          phase_ct_next = phase_ct_reg - 1'b1;
        end
      end
      DRAIN: begin
        if (phase_ct_reg == '0) begin
          state_next = DONE;
        end else begin
          phase_ct_next = phase_ct_reg - 1'b1;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy_o     = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      phase_ct_reg <= '0;
      dec_en_reg   <= 1'b0;
      word_ct_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      phase_ct_reg <= phase_ct_next;
      dec_en_reg   <= enc_en_o;
      if (start_ok) begin
        word_ct_reg <= '0;
      end else if (enc_en_o) begin
        word_ct_reg <= sat_add(word_ct_reg, 2'd1);
      end
    end
  end

  assign dec_en_o  = dec_en_reg;
  assign word_ct_o = word_ct_reg;

`ifdef VITERBI_ERR_INJECT_EN
  localparam logic [15:0] HIT_MASK = 16'((1 << ERR_N) - 1);

  logic [15:0]      lfsr_q;
  logic [1:0]       mask_reg, mask_next;
  logic [CNT_W-1:0] err_ct_reg;

  viterbi_err_lfsr u_err_lfsr (
    .clk      (clk),
    .rst      (rst),
    .adv_i    (enc_en_o),
    .reseed_i (start_ok),
    .q_o      (lfsr_q)
  );

  // Mask is computed from the LFSR value before it steps, so it lines up with dec_en
  always_comb begin
    mask_next = 2'b00;
    if (enc_en_o && ((lfsr_q & HIT_MASK) == HIT_MASK)) begin
      mask_next = lfsr_q[ERR_N+1 -: 2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_reg   <= 2'b00;
      err_ct_reg <= '0;
    end else begin
      mask_reg <= mask_next;
      if (start_ok) begin
        err_ct_reg <= '0;
      end else begin
        err_ct_reg <= sat_add(err_ct_reg, popcount2(mask_reg));
      end
    end
  end

  assign err_mask_o = mask_reg;
  assign err_ct_o   = err_ct_reg;
`else
  assign err_mask_o = 2'b00;
  assign err_ct_o   = '0;
`endif

endmodule
